// File: rtl/ps2_keycode_rx_pkg.sv
// Shared definitions for the PS/2 keycode receiver: prefix bytes,
// frame FSM states and the event record stored in the FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
    logic       brk;
  } ps2_event_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame deframer: synchronise and
// glitch-filter both lines, then shift in bytes on falling PS2Clk edges.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       frame_err
);

  localparam int CW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  // index 0 carries PS2Clk, index 1 carries PS2Data
  logic [1:0]    s1, s2, filt;
  logic [CW-1:0] fcnt [2];
  logic          clk_prev;

  ps2_state_t    state, next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] timer;

  logic fall, data_f, timeout, stop_ok, stop_bad;

  // A filtered line only follows the synchroniser after FILTER_LEN differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 2'b11;
      s2       <= 2'b11;
      filt     <= 2'b11;
      clk_prev <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      s1       <= {PS2Data, PS2Clk};
      s2       <= s1;
      clk_prev <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i] <= s2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall     = clk_prev & ~filt[0];
  assign data_f   = filt[1];
  assign timeout  = (state != IDLE) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));
  assign stop_ok  = (state == STOP) && fall && data_f && (^{shift, par_bit});
  assign stop_bad = (state == STOP) && fall && !(data_f && (^{shift, par_bit}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (fall && !data_f) next = DATA;
      DATA:    if (fall && bit_cnt == 3'd7) next = PARITY;
      PARITY:  if (fall) next = STOP;
      STOP:    if (fall) next = IDLE;
      default: next = IDLE;
    endcase
    if (timeout) next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      shift       <= '0;
      par_bit     <= 1'b0;
      timer       <= '0;
      rx_byte     <= '0;
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      byte_strobe <= stop_ok;
      frame_err   <= stop_bad | timeout;
      if (stop_ok) rx_byte <= shift;
      if (state == IDLE || fall) timer <= '0;
      else                       timer <= timer + 1'b1;
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (state == DATA && fall) begin
        shift   <= {data_f, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == PARITY && fall) par_bit <= data_f;
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver top: folds E0/F0 prefixes into make/break events
// and queues them in a first-word-fall-through FIFO with valid/ready.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          PS2Clk,
  input  logic                          PS2Data,
  output logic [15:0]                   keycode,
  output logic                          key_break,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]  rx_byte;
  logic        byte_strobe;
  logic        ext, brk, push;
  ps2_event_t  push_ev, head, hold;
  ps2_event_t  mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic        pop, full, wr;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk        (clk),
    .rst_n      (rst_n),
    .PS2Clk     (PS2Clk),
    .PS2Data    (PS2Data),
    .rx_byte    (rx_byte),
    .byte_strobe(byte_strobe),
    .frame_err  (frame_err)
  );

  // Prefix bytes only arm flags; the next ordinary byte carries them into the event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext     <= 1'b0;
      brk     <= 1'b0;
      push    <= 1'b0;
      push_ev <= '0;
    end else begin
      push <= 1'b0;
      if (frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_strobe) begin
        if (rx_byte == PS2_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == PS2_BRK) begin
          brk <= 1'b1;
        end else begin
          push         <= 1'b1;
          push_ev.ext  <= ext;
          push_ev.code <= rx_byte;
          push_ev.brk  <= brk;
          ext          <= 1'b0;
          brk          <= 1'b0;
        end
      end
    end
  end

  assign key_valid  = (count != '0);
  assign full       = (count == FULL_CNT);
  assign pop        = key_valid & key_ready;
  assign wr         = push & (~full | pop);
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= push_ev;
  end

  // hold keeps the last popped entry so outputs stay put while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      hold     <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full & ~pop;
      if (wr) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        hold <= mem[rptr];
      end
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head      = key_valid ? mem[rptr] : hold;
  assign keycode   = {head.ext ? PS2_EXT : 8'h00, head.code};
  assign key_break = head.brk;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: drives PS/2 frames bit by bit and
// compares FIFO output events against a queue of expected events.
module tb_ps2_keycode_rx;

  localparam int FILTER_LEN     = 4;
  localparam int FIFO_DEPTH     = 8;
  localparam int TIMEOUT_CYCLES = 20000;
  localparam int CNTW           = $clog2(FIFO_DEPTH) + 1;
  localparam int HALF           = 20;
  // PS2Clk fall -> key_valid: 2 sync + filter + byte_strobe + push + write
  localparam int LAT            = FILTER_LEN + 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            PS2Clk = 1'b1;
  logic            PS2Data = 1'b1;
  logic            key_ready = 1'b0;
  logic [15:0]     keycode;
  logic            key_break, key_valid, frame_err, overflow;
  logic [CNTW-1:0] fifo_count;

  int total = 0;
  int bad = 0;
  int err_pulses = 0;
  int ovf_pulses = 0;
  logic [16:0] exp_q[$];
  logic [16:0] exp;

  ps2_keycode_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PS2Clk    (PS2Clk),
    .PS2Data   (PS2Data),
    .keycode   (keycode),
    .key_break (key_break),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .fifo_count(fifo_count),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (overflow)  ovf_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    PS2Data = b;
    tick(HALF);
    PS2Clk = 1'b0;
    tick(HALF);
    PS2Clk = 1'b1;
  endtask

  // leaves PS2Clk low just after the stop-bit falling edge
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit((~^b) ^ bad_par);
    PS2Data = ~bad_stop;
    tick(HALF);
    PS2Clk = 1'b0;
  endtask

  task automatic finish_frame();
    tick(HALF);
    PS2Clk  = 1'b1;
    PS2Data = 1'b1;
    tick(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
    finish_frame();
  endtask

  task automatic test_reset();
    tick(3);
    total++;
    if ({keycode, key_break, key_valid, fifo_count, frame_err, overflow} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_hold: got kc=%h brk=%b v=%b cnt=%0d err=%b ovf=%b, want all 0",
               keycode, key_break, key_valid, fifo_count, frame_err, overflow);
    end
    rst_n = 1'b1;
    tick(3);
    total++;
    if ({keycode, key_break, key_valid, fifo_count} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_release: got kc=%h brk=%b v=%b cnt=%0d, want all 0",
               keycode, key_break, key_valid, fifo_count);
    end
  endtask

  task automatic test_make_latency();
    exp_q.push_back({1'b0, 16'h001C});
    send_frame(8'h1C, 1'b0, 1'b0);
    tick(LAT - 1);
    total++;
    if (key_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL make_early: key_valid=%b want 0 at N+2", key_valid);
    end
    tick(1);
    total++;
    if (key_valid !== 1'b1 || fifo_count !== CNTW'(1)) begin
      bad++; $display("[TB] FAIL make_valid: valid=%b cnt=%0d want 1/1 at N+3", key_valid, fifo_count);
    end
    exp = exp_q.pop_front();
    total++;
    if ({key_break, keycode} !== exp) begin
      bad++; $display("[TB] FAIL make_code: got %b_%h want %b_%h", key_break, keycode, exp[16], exp[15:0]);
    end
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    total++;
    if (key_valid !== 1'b0 || fifo_count !== '0 || keycode !== 16'h001C) begin
      bad++; $display("[TB] FAIL make_pop_hold: valid=%b cnt=%0d kc=%h want 0/0/001c", key_valid, fifo_count, keycode);
    end
    finish_frame();
  endtask

  task automatic test_break();
    send_byte(8'hF0);
    total++;
    if (key_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL break_prefix_only: key_valid=%b want 0", key_valid);
    end
    exp_q.push_back({1'b1, 16'h001C});
    send_byte(8'h1C);
    exp = exp_q.pop_front();
    total++;
    if (key_valid !== 1'b1 || {key_break, keycode} !== exp || fifo_count !== CNTW'(1)) begin
      bad++; $display("[TB] FAIL break_event: v=%b cnt=%0d got %b_%h want %b_%h", key_valid, fifo_count,
                      key_break, keycode, exp[16], exp[15:0]);
    end
    key_ready = 1'b1; tick(1); key_ready = 1'b0;
  endtask

  task automatic test_ext_break();
    key_ready = 1'b1;
    exp_q.push_back({1'b1, 16'hE075});
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_frame(8'h75, 1'b0, 1'b0);
    tick(LAT);
    exp = exp_q.pop_front();
    total++;
    if (key_valid !== 1'b1 || {key_break, keycode} !== exp) begin
      bad++; $display("[TB] FAIL ext_event: v=%b got %b_%h want %b_%h", key_valid, key_break, keycode, exp[16], exp[15:0]);
    end
    tick(1);
    total++;
    if (key_valid !== 1'b0 || fifo_count !== '0) begin
      bad++; $display("[TB] FAIL ext_popped: v=%b cnt=%0d want 0/0", key_valid, fifo_count);
    end
    key_ready = 1'b0;
    finish_frame();
  endtask

  task automatic test_frame_errors();
    int err0;
    err0 = err_pulses;
    send_frame(8'h1C, 1'b1, 1'b0);
    finish_frame();
    total++;
    if (err_pulses !== err0 + 1 || key_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL parity_err: pulses=%0d valid=%b want %0d/0", err_pulses - err0, key_valid, 1);
    end
    send_byte(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b1);
    finish_frame();
    total++;
    if (err_pulses !== err0 + 2 || key_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL stop_err: pulses=%0d valid=%b want %0d/0", err_pulses - err0, key_valid, 2);
    end
    exp_q.push_back({1'b0, 16'h001C});
    send_byte(8'h1C);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      total++;
      if (key_valid !== 1'b1 || {key_break, keycode} !== exp) begin
        bad++; $display("[TB] FAIL err_recover: v=%b got %b_%h want %b_%h", key_valid, key_break, keycode, exp[16], exp[15:0]);
      end
      key_ready = 1'b1; tick(1); key_ready = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int err0, waited;
    logic [4:0] bits;
    err0 = err_pulses;
    bits = 5'b01101;
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(bits[i]);
    tick(TIMEOUT_CYCLES - 100);
    total++;
    if (err_pulses !== err0) begin
      bad++; $display("[TB] FAIL timeout_early: pulses=%0d want 0", err_pulses - err0);
    end
    waited = 0;
    while (err_pulses == err0 && waited < 400) begin
      tick(1);
      waited++;
    end
    total++;
    if (err_pulses !== err0 + 1) begin
      bad++; $display("[TB] FAIL timeout_err: pulses=%0d want 1 within bound", err_pulses - err0);
    end
    exp_q.push_back({1'b0, 16'h002D});
    send_byte(8'h2D);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      total++;
      if (key_valid !== 1'b1 || {key_break, keycode} !== exp) begin
        bad++; $display("[TB] FAIL timeout_recover: v=%b got %b_%h want %b_%h", key_valid, key_break, keycode, exp[16], exp[15:0]);
      end
      key_ready = 1'b1; tick(1); key_ready = 1'b0;
    end
  endtask

  task automatic test_overflow();
    int ovf0;
    ovf0 = ovf_pulses;
    for (int i = 1; i <= FIFO_DEPTH + 1; i++) begin
      if (i <= FIFO_DEPTH) exp_q.push_back({1'b0, 8'h00, 8'(i)});
      send_byte(8'(i));
    end
    total++;
    if (fifo_count !== CNTW'(FIFO_DEPTH) || ovf_pulses !== ovf0 + 1) begin
      bad++; $display("[TB] FAIL ovf_fill: cnt=%0d pulses=%0d want %0d/1", fifo_count, ovf_pulses - ovf0, FIFO_DEPTH);
    end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      total++;
      if (key_valid !== 1'b1 || {key_break, keycode} !== exp) begin
        bad++; $display("[TB] FAIL ovf_drain: v=%b got %b_%h want %b_%h", key_valid, key_break, keycode, exp[16], exp[15:0]);
      end
      key_ready = 1'b1; tick(1); key_ready = 1'b0;
    end
    total++;
    if (key_valid !== 1'b0 || fifo_count !== '0) begin
      bad++; $display("[TB] FAIL ovf_empty: v=%b cnt=%0d want 0/0", key_valid, fifo_count);
    end
  endtask

  task automatic test_full_push_pop();
    int ovf0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      exp_q.push_back({1'b0, 8'h00, 8'(8'h11 + i)});
      send_byte(8'(8'h11 + i));
    end
    ovf0 = ovf_pulses;
    send_frame(8'h19, 1'b0, 1'b0);
    tick(LAT - 1);
    key_ready = 1'b1;
    exp = exp_q.pop_front();
    exp_q.push_back({1'b0, 16'h0019});
    total++;
    if (key_valid !== 1'b1 || {key_break, keycode} !== exp) begin
      bad++; $display("[TB] FAIL full_head: v=%b got %b_%h want %b_%h", key_valid, key_break, keycode, exp[16], exp[15:0]);
    end
    tick(1);
    key_ready = 1'b0;
    tick(1);
    total++;
    if (fifo_count !== CNTW'(FIFO_DEPTH) || ovf_pulses !== ovf0) begin
      bad++; $display("[TB] FAIL full_push_pop: cnt=%0d pulses=%0d want %0d/0", fifo_count, ovf_pulses - ovf0, FIFO_DEPTH);
    end
    finish_frame();
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      total++;
      if (key_valid !== 1'b1 || {key_break, keycode} !== exp) begin
        bad++; $display("[TB] FAIL full_drain: v=%b got %b_%h want %b_%h", key_valid, key_break, keycode, exp[16], exp[15:0]);
      end
      key_ready = 1'b1; tick(1); key_ready = 1'b0;
    end
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h44);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst_n = 1'b0;
    tick(2);
    total++;
    if (key_valid !== 1'b0 || fifo_count !== '0 || keycode !== 16'h0000 || key_break !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_mid: v=%b cnt=%0d kc=%h brk=%b want all 0", key_valid, fifo_count, keycode, key_break);
    end
    rst_n = 1'b1;
    PS2Data = 1'b1;
    tick(HALF);
    exp_q.push_back({1'b0, 16'h0033});
    send_byte(8'h33);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      total++;
      if (key_valid !== 1'b1 || fifo_count !== CNTW'(1) || {key_break, keycode} !== exp) begin
        bad++; $display("[TB] FAIL reset_mid_next: v=%b cnt=%0d got %b_%h want %b_%h", key_valid, fifo_count,
                        key_break, keycode, exp[16], exp[15:0]);
      end
      key_ready = 1'b1; tick(1); key_ready = 1'b0;
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_make_latency();
    test_break();
    test_ext_break();
    test_frame_errors();
    test_timeout();
    test_overflow();
    test_full_push_pop();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
